// File: rtl/muldiv_ctrl_if.sv
// Command/result bundle between the EX stage and the HI/LO multiply/divide unit.
// The master issues commands; the slave owns HI/LO and reports busy/done.
interface muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative MIPS HI/LO multiply/divide sequencer: one shift-add or restoring
// shift-subtract step per cycle on a shared 2*WIDTH accumulator, then sign fix-up.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_ctrl_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opB_q, opB_d;
  logic               signA_q, signA_d;
  logic               signB_q, signB_d;
  logic               isDiv_q, isDiv_d;
  logic               divZero_q, divZero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               isSignedOp;
  logic               isDivOp;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     divShift;
  logic [WIDTH:0]     divDiff;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  // Accumulator holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opB_d      = opB_q;
    signA_d    = signA_q;
    signB_d    = signB_q;
    isDiv_d    = isDiv_q;
    divZero_d  = divZero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    isSignedOp = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    isDivOp    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    magA       = (isSignedOp && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
    magB       = (isSignedOp && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;

    mulSum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opB_q} : '0);
    divShift   = acc_q[2*WIDTH-1:WIDTH-1];
    divDiff    = divShift - {1'b0, opB_q};
    quo        = acc_q[WIDTH-1:0];
    rem        = acc_q[2*WIDTH-1:WIDTH];

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              signA_d   = isSignedOp & bus.a[WIDTH-1];
              signB_d   = isSignedOp & bus.b[WIDTH-1];
              isDiv_d   = isDivOp;
              divZero_d = (bus.b == '0);
              opB_d     = isDivOp ? magB : magA;
              acc_d     = {{WIDTH{1'b0}}, (isDivOp ? magA : magB)};
              cnt_d     = CW'(WIDTH);
              state_d   = isDivOp ? DIV : MUL;
            end
            OP_MTHI: hi_d = bus.a;
            OP_MTLO: lo_d = bus.a;
            default: ;
          endcase
        end
      end
      MUL: begin
        acc_d = {mulSum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      DIV: begin
        if (!divDiff[WIDTH]) acc_d = {divDiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else                 acc_d = {divShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        // A zero divisor yields an all-ones quotient magnitude; force it so signed DIV matches DIVU.
        if (isDiv_q) begin
          lo_d = divZero_q ? '1 : ((signA_q ^ signB_q) ? (~quo + 1'b1) : quo);
          hi_d = signA_q ? (~rem + 1'b1) : rem;
        end else begin
          {hi_d, lo_d} = (signA_q ^ signB_q) ? (~acc_q + 1'b1) : acc_q;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opB_q     <= '0;
      signA_q   <= 1'b0;
      signB_q   <= 1'b0;
      isDiv_q   <= 1'b0;
      divZero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opB_q     <= opB_d;
      signA_q   <= signA_d;
      signB_q   <= signB_d;
      isDiv_q   <= isDiv_d;
      divZero_q <= divZero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vector table, timing corner cases,
// and random commands compared against a plain-arithmetic HI/LO model.
module tb_muldiv_ctrl;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [31:0] refHi = '0;
  logic [31:0] refLo = '0;

  muldiv_ctrl_if #(.WIDTH(32)) bus ();

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One-cycle command pulse; returns at the falling edge right after the accepting edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 3'b000;
  endtask

  // Returns at the falling edge of the done cycle, or after the bound with seen=0.
  task automatic waitDone(output logic [31:0] hiV, output logic [31:0] loV,
                          output int busyCnt, output bit seen, output logic busyAtDone);
    busyCnt = 0;
    seen = 1'b0;
    hiV = 'x;
    loV = 'x;
    busyAtDone = 1'bx;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        hiV = bus.hi;
        loV = bus.lo;
        busyAtDone = bus.busy;
      end else begin
        if (bus.busy) busyCnt++;
        @(negedge clk);
      end
    end
  endtask

  function automatic void refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   inout logic [31:0] hi, inout logic [31:0] lo);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULT:  begin p = 64'(sa * sb); {hi, lo} = p; end
      OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; {hi, lo} = p; end
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else if (op == OP_DIV) begin
          q = sa / sb;
          r = sa % sb;
          p = 64'(q); lo = p[31:0];
          p = 64'(r); hi = p[31:0];
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
      OP_MTHI: hi = a;
      OP_MTLO: lo = a;
      default: ;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[9];
    logic [31:0] hiV, loV;
    int busyCnt;
    bit seen;
    logic busyAtDone;
    logic [2:0] rop;
    logic [31:0] ra, rb;

    vecs[0] = '{"multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{"mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{"mult_min2", OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[3] = '{"div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4] = '{"divu_100",  OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
    vecs[5] = '{"divu_zero", OP_DIVU,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF};
    vecs[6] = '{"div_zero",  OP_DIV,   32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF};
    vecs[7] = '{"div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[8] = '{"div_negb",  OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};

    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = '0;
    bus.b     = '0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", 64'(bus.busy), 64'd0);
    checkOutput("reset_done", 64'(bus.done), 64'd0);
    checkOutput("reset_hi", 64'(bus.hi), 64'd0);
    checkOutput("reset_lo", 64'(bus.lo), 64'd0);
    rst_n = 1'b1;

    $display("[TB] directed vector table");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      waitDone(hiV, loV, busyCnt, seen, busyAtDone);
      checkOutput({vecs[i].name, "_done_seen"}, 64'(seen), 64'd1);
      checkOutput({vecs[i].name, "_busy_cycles"}, 64'(busyCnt), 64'd33);
      checkOutput({vecs[i].name, "_busy_at_done"}, 64'(busyAtDone), 64'd0);
      checkOutput({vecs[i].name, "_hi"}, 64'(hiV), 64'(vecs[i].expHi));
      checkOutput({vecs[i].name, "_lo"}, 64'(loV), 64'(vecs[i].expLo));
      @(negedge clk);
      checkOutput({vecs[i].name, "_done_pulse"}, 64'(bus.done), 64'd0);
      refHi = vecs[i].expHi;
      refLo = vecs[i].expLo;
    end

    $display("[TB] MTHI while idle");
    applyStimulus(OP_MTHI, 32'hAAAA_5555, 32'd0);
    checkOutput("mthi_hi", 64'(bus.hi), 64'hAAAA_5555);
    checkOutput("mthi_lo_kept", 64'(bus.lo), 64'(refLo));
    checkOutput("mthi_busy", 64'(bus.busy), 64'd0);
    checkOutput("mthi_done", 64'(bus.done), 64'd0);

    $display("[TB] commands ignored while a divide is busy");
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIV;  bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk);
    bus.op = OP_MTLO; bus.a = 32'd1;
    @(negedge clk);
    bus.op = OP_MULT; bus.a = 32'd3; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'b000;
    waitDone(hiV, loV, busyCnt, seen, busyAtDone);
    checkOutput("busy_ign_done_seen", 64'(seen), 64'd1);
    checkOutput("busy_ign_lo", 64'(loV), 64'd14);
    checkOutput("busy_ign_hi", 64'(hiV), 64'd2);
    @(negedge clk);
    checkOutput("busy_ign_no_mult", 64'(bus.busy), 64'd0);

    $display("[TB] start in FIX cycle is ignored");
    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    repeat (32) @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MTHI; bus.a = 32'h5;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'b000;
    checkOutput("fix_ign_done", 64'(bus.done), 64'd1);
    checkOutput("fix_ign_hi", 64'(bus.hi), 64'd2);
    @(negedge clk);
    checkOutput("fix_ign_hi_after", 64'(bus.hi), 64'd2);

    $display("[TB] start in done cycle is accepted");
    applyStimulus(OP_MULTU, 32'd3, 32'd4);
    waitDone(hiV, loV, busyCnt, seen, busyAtDone);
    checkOutput("b2b_first_lo", 64'(loV), 64'd12);
    bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd9; bus.b = 32'd9;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'b000;
    checkOutput("b2b_accept_busy", 64'(bus.busy), 64'd1);
    waitDone(hiV, loV, busyCnt, seen, busyAtDone);
    checkOutput("b2b_second_seen", 64'(seen), 64'd1);
    checkOutput("b2b_second_lo", 64'(loV), 64'd81);
    checkOutput("b2b_second_hi", 64'(hiV), 64'd0);

    $display("[TB] reset mid-operation");
    applyStimulus(OP_MULTU, 32'd5, 32'd6);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy", 64'(bus.busy), 64'd0);
    checkOutput("midrst_done", 64'(bus.done), 64'd0);
    checkOutput("midrst_hi", 64'(bus.hi), 64'd0);
    checkOutput("midrst_lo", 64'(bus.lo), 64'd0);
    rst_n = 1'b1;
    applyStimulus(OP_MULTU, 32'd5, 32'd6);
    waitDone(hiV, loV, busyCnt, seen, busyAtDone);
    checkOutput("midrst_retry_seen", 64'(seen), 64'd1);
    checkOutput("midrst_retry_lo", 64'(loV), 64'd30);
    checkOutput("midrst_retry_hi", 64'(hiV), 64'd0);
    refHi = 32'd0;
    refLo = 32'd30;

    $display("[TB] random commands against reference model");
    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(1, 6));
      ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 50));
        default: rb = $urandom;
      endcase
      refModel(rop, ra, rb, refHi, refLo);
      applyStimulus(rop, ra, rb);
      if (rop == OP_MTHI || rop == OP_MTLO) begin
        checkOutput($sformatf("rand%0d_mt_busy", n), 64'(bus.busy), 64'd0);
        checkOutput($sformatf("rand%0d_mt_hi", n), 64'(bus.hi), 64'(refHi));
        checkOutput($sformatf("rand%0d_mt_lo", n), 64'(bus.lo), 64'(refLo));
      end else begin
        waitDone(hiV, loV, busyCnt, seen, busyAtDone);
        checkOutput($sformatf("rand%0d_op%0d_seen", n, rop), 64'(seen), 64'd1);
        checkOutput($sformatf("rand%0d_op%0d_a%h_b%h_hi", n, rop, ra, rb), 64'(hiV), 64'(refHi));
        checkOutput($sformatf("rand%0d_op%0d_a%h_b%h_lo", n, rop, ra, rb), 64'(loV), 64'(refLo));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
